// File: rtl/alu_seq.sv
// alu_seq: clocked ALU with in_valid/in_ready handshake, iterative MUL/DIV and internal NZCV flags
// Optional macro ALU_SEQ_DIV_EN enables the unsigned restoring divide on opcode 1000.
// Ports: clk, rst (sync, active-high); in_valid/in_ready handshake; opcode, cond, s, sr_cont,
// sr_bit, in1, in2, imm operation inputs; out_valid pulse with result, flags {N,Z,C,V},
// cond_met and div_zero.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHAMT_W = 5,
  parameter int IMM_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         opcode,
  input  logic [3:0]         cond,
  input  logic               s,
  input  logic [2:0]         sr_cont,
  input  logic [SHAMT_W-1:0] sr_bit,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic [IMM_W-1:0]   imm,
  output logic               out_valid,
  output logic [WIDTH-1:0]   result,
  output logic [3:0]         flags,
  output logic               cond_met,
  output logic               div_zero
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_MUL = 4'h2, OP_OR = 4'h3, OP_AND = 4'h4,
                         OP_XOR = 4'h5, OP_MOVI = 4'h6, OP_MOV = 4'h7, OP_DIV = 4'h8, OP_CMP = 4'hB,
                         OP_LDR = 4'hD, OP_STR = 4'hE;
  state_t state;
  logic [SHAMT_W-1:0] cnt;
  logic [2*WIDTH-1:0] acc, mc, acc_n, prod;
  logic [WIDTH-1:0] mp, op2, r1, mag1, mag2;
  logic signed [WIDTH-1:0] asr_w;
  logic [SHAMT_W:0] rsh;
  logic [WIDTH:0] sum_w, dif_w;
  logic neg_q, s_q, cm, c1, v1, upd, mul_v;
  assign in_ready = state == IDLE;
  assign asr_w = $signed(in2) >>> sr_bit;
  assign rsh = (SHAMT_W+1)'(WIDTH) - {1'b0, sr_bit};
  assign op2 = sr_cont == 3'b001 ? in2 >> sr_bit :
               sr_cont == 3'b010 ? in2 << sr_bit :
               sr_cont == 3'b011 ? (in2 >> sr_bit) | (in2 << rsh) :
               sr_cont == 3'b100 ? asr_w : in2;
  assign sum_w = {1'b0, in1} + {1'b0, op2};
  assign dif_w = {1'b0, in1} - {1'b0, op2};
  assign mag1 = in1[WIDTH-1] ? -in1 : in1;
  assign mag2 = op2[WIDTH-1] ? -op2 : op2;
  // Shift-add step on magnitudes; the sign is restored only on the final product.
  assign acc_n = acc + (mp[0] ? mc : '0);
  assign prod = neg_q ? -acc_n : acc_n;
  assign mul_v = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
  always_comb begin
    cm = 1'b0;
    case (cond)
      4'd0: cm = 1'b1;
      4'd1: cm = in1 == in2;
      4'd2: cm = $signed(in1) > $signed(in2);
      4'd3: cm = $signed(in1) < $signed(in2);
      4'd4: cm = $signed(in1) >= $signed(in2);
      4'd5: cm = $signed(in1) <= $signed(in2);
      4'd6: cm = in1 > in2;
      4'd7: cm = in1 < in2;
      4'd8: cm = in1 >= in2;
      default: cm = 1'b0;
    endcase
  end
  always_comb begin
    r1 = '0;
    c1 = 1'b0;
    v1 = 1'b0;
    upd = 1'b1;
    case (opcode)
      OP_ADD: begin
        {c1, r1} = sum_w;
        v1 = (in1[WIDTH-1] == op2[WIDTH-1]) && (sum_w[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_SUB, OP_CMP: begin
        r1 = dif_w[WIDTH-1:0];
        c1 = !dif_w[WIDTH];
        v1 = (in1[WIDTH-1] != op2[WIDTH-1]) && (dif_w[WIDTH-1] != in1[WIDTH-1]);
      end
      OP_OR: r1 = in1 | op2;
      OP_AND: r1 = in1 & op2;
      OP_XOR: r1 = in1 ^ op2;
      OP_MOVI: r1 = {{(WIDTH-IMM_W){1'b0}}, imm};
      OP_MOV, OP_LDR, OP_STR: r1 = in1;
      default: upd = 1'b0;
    endcase
  end
`ifdef ALU_SEQ_DIV_EN
  // Restoring divide: remainder in acc, dividend shifts out of mp while quotient bits shift in.
  logic [WIDTH:0] rem_sh, rem_d, rem_n;
  logic [WIDTH-1:0] q_n;
  assign rem_sh = {acc[WIDTH-1:0], mp[WIDTH-1]};
  assign rem_d = rem_sh - {1'b0, mc[WIDTH-1:0]};
  assign rem_n = rem_d[WIDTH] ? rem_sh : rem_d;
  assign q_n = {mp[WIDTH-2:0], !rem_d[WIDTH]};
`else
  assign div_zero = 1'b0;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      out_valid <= 1'b0;
      result <= '0;
      flags <= '0;
      cond_met <= 1'b0;
      cnt <= '0;
      acc <= '0;
      mc <= '0;
      mp <= '0;
      neg_q <= 1'b0;
      s_q <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      div_zero <= 1'b0;
`endif
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          s_q <= s;
          cnt <= '0;
          acc <= '0;
          if (cm && opcode == OP_MUL) begin
            state <= MUL;
            mc <= {{WIDTH{1'b0}}, mag1};
            mp <= mag2;
            neg_q <= in1[WIDTH-1] ^ op2[WIDTH-1];
          end
`ifdef ALU_SEQ_DIV_EN
          else if (cm && opcode == OP_DIV && op2 != '0) begin
            state <= DIV;
            mc <= {{WIDTH{1'b0}}, op2};
            mp <= in1;
          end else if (cm && opcode == OP_DIV) begin
            state <= DONE;
            out_valid <= 1'b1;
            result <= '1;
            cond_met <= 1'b1;
            div_zero <= 1'b1;
            if (s) flags <= 4'b1000;
          end
`endif
          else begin
            state <= DONE;
            out_valid <= 1'b1;
            result <= cm ? r1 : '0;
            cond_met <= cm;
`ifdef ALU_SEQ_DIV_EN
            div_zero <= 1'b0;
`endif
            if (cm && upd && (s || opcode == OP_CMP)) flags <= {r1[WIDTH-1], r1 == '0, c1, v1};
          end
        end
        MUL: begin
          acc <= acc_n;
          mc <= mc << 1;
          mp <= mp >> 1;
          cnt <= cnt + 1'b1;
          if (cnt == SHAMT_W'(WIDTH-1)) begin
            state <= DONE;
            out_valid <= 1'b1;
            result <= prod[WIDTH-1:0];
            cond_met <= 1'b1;
`ifdef ALU_SEQ_DIV_EN
            div_zero <= 1'b0;
`endif
            if (s_q) flags <= {prod[WIDTH-1], prod[WIDTH-1:0] == '0, 1'b0, mul_v};
          end
        end
`ifdef ALU_SEQ_DIV_EN
        DIV: begin
          acc <= {{(WIDTH-1){1'b0}}, rem_n};
          mp <= q_n;
          cnt <= cnt + 1'b1;
          if (cnt == SHAMT_W'(WIDTH-1)) begin
            state <= DONE;
            out_valid <= 1'b1;
            result <= q_n;
            cond_met <= 1'b1;
            div_zero <= 1'b0;
            if (s_q) flags <= {q_n[WIDTH-1], q_n == '0, 2'b00};
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq
module tb_alu_seq;
  logic clk = 0, rst = 1, in_valid = 0, s = 0;
  logic [3:0] opcode = 0, cond = 0;
  logic [2:0] sr_cont = 0;
  logic [4:0] sr_bit = 0;
  logic [31:0] in1 = 0, in2 = 0;
  logic [15:0] imm = 0;
  logic in_ready, out_valid, cond_met, div_zero;
  logic [31:0] result;
  logic [3:0] flags;
  int checks = 0, errors = 0, lat;
  alu_seq #(.WIDTH(32), .SHAMT_W(5), .IMM_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .cond(cond),
    .s(s), .sr_cont(sr_cont), .sr_bit(sr_bit), .in1(in1), .in2(in2), .imm(imm),
    .out_valid(out_valid), .result(result), .flags(flags), .cond_met(cond_met), .div_zero(div_zero)
  );
  always #5 clk = ~clk;
  task automatic run_op(input logic [3:0] op, input logic [3:0] c, input logic sf, input logic [2:0] sc,
                        input logic [4:0] sb, input logic [31:0] a, input logic [31:0] b,
                        input logic [15:0] im, output int l);
    int w = 0;
    @(negedge clk);
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    opcode = op; cond = c; s = sf; sr_cont = sc; sr_bit = sb; in1 = a; in2 = b; imm = im; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0; in1 = $urandom; in2 = $urandom; imm = 16'h5A5A; opcode = 4'hF; cond = 4'hF; s = ~sf; sr_cont = 3'b111;
    l = 1;
    while (!out_valid && l < 100) begin @(posedge clk); #1; l++; end
  endtask
  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    checks++; if (flags !== 4'h0) begin errors++; $display("FAIL reset_flags: got %b want 0000", flags); end
    checks++; if ({cond_met, div_zero} !== 2'b00) begin errors++; $display("FAIL reset_cm_dz: got %b want 00", {cond_met, div_zero}); end
    rst = 0;
  endtask
  task automatic test_add;
    run_op(4'h0, 4'd0, 1, 3'b000, 0, 32'h7FFFFFFF, 32'h1, 0, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL add_latency: got %0d want 1", lat); end
    checks++; if (result !== 32'h80000000) begin errors++; $display("FAIL add_result: got %h want 80000000", result); end
    checks++; if (flags !== 4'b1001) begin errors++; $display("FAIL add_flags: got %b want 1001", flags); end
    checks++; if (cond_met !== 1'b1) begin errors++; $display("FAIL add_cond_met: got %b want 1", cond_met); end
  endtask
  task automatic test_cmp;
    run_op(4'hB, 4'd0, 0, 3'b000, 0, 32'd5, 32'd5, 0, lat);
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL cmp_result: got %h want 0", result); end
    checks++; if (flags !== 4'b0110) begin errors++; $display("FAIL cmp_flags: got %b want 0110", flags); end
    run_op(4'h0, 4'd1, 0, 3'b000, 0, 32'd3, 32'd3, 0, lat);
    checks++; if (result !== 32'd6) begin errors++; $display("FAIL eq_add_result: got %h want 6", result); end
    checks++; if (cond_met !== 1'b1) begin errors++; $display("FAIL eq_add_cond_met: got %b want 1", cond_met); end
    checks++; if (flags !== 4'b0110) begin errors++; $display("FAIL eq_add_flags_hold: got %b want 0110", flags); end
  endtask
  task automatic test_cond;
    run_op(4'h1, 4'd2, 1, 3'b000, 0, 32'hFFFFFFFF, 32'h1, 0, lat);
    checks++; if (cond_met !== 1'b0) begin errors++; $display("FAIL gt_cond_met: got %b want 0", cond_met); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL gt_result: got %h want 0", result); end
    checks++; if (flags !== 4'b0110) begin errors++; $display("FAIL gt_flags_hold: got %b want 0110", flags); end
    checks++; if (lat !== 1) begin errors++; $display("FAIL gt_latency: got %0d want 1", lat); end
    run_op(4'h1, 4'd6, 1, 3'b000, 0, 32'hFFFFFFFF, 32'h1, 0, lat);
    checks++; if (cond_met !== 1'b1) begin errors++; $display("FAIL hi_cond_met: got %b want 1", cond_met); end
    checks++; if (result !== 32'hFFFFFFFE) begin errors++; $display("FAIL hi_result: got %h want fffffffe", result); end
    checks++; if (flags !== 4'b1010) begin errors++; $display("FAIL hi_flags: got %b want 1010", flags); end
    run_op(4'h0, 4'd9, 1, 3'b000, 0, 32'd1, 32'd1, 0, lat);
    checks++; if ({cond_met, result} !== {1'b0, 32'h0}) begin errors++; $display("FAIL never_cond: got %b/%h want 0/0", cond_met, result); end
  endtask
  task automatic test_mul;
    run_op(4'h2, 4'd0, 1, 3'b001, 4, 32'hFFFFFFFD, 32'h10, 0, lat);
    checks++; if (lat !== 33) begin errors++; $display("FAIL mul_latency: got %0d want 33", lat); end
    checks++; if (result !== 32'hFFFFFFFD) begin errors++; $display("FAIL mul_result: got %h want fffffffd", result); end
    checks++; if (flags !== 4'b1000) begin errors++; $display("FAIL mul_flags: got %b want 1000", flags); end
    run_op(4'h2, 4'd0, 1, 3'b000, 0, 32'h10000, 32'h10000, 0, lat);
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL mul_ovf_result: got %h want 0", result); end
    checks++; if (flags !== 4'b0101) begin errors++; $display("FAIL mul_ovf_flags: got %b want 0101", flags); end
    run_op(4'h2, 4'd0, 0, 3'b000, 0, 32'hFFFFFFF9, 32'hFFFFFFFA, 0, lat);
    checks++; if (result !== 32'd42) begin errors++; $display("FAIL mul_negneg: got %h want 2a", result); end
  endtask
  task automatic test_shift;
    run_op(4'h3, 4'd0, 0, 3'b100, 31, 32'h0, 32'h80000000, 0, lat);
    checks++; if (result !== 32'hFFFFFFFF) begin errors++; $display("FAIL asr: got %h want ffffffff", result); end
    run_op(4'h3, 4'd0, 0, 3'b011, 8, 32'h0, 32'hAB, 0, lat);
    checks++; if (result !== 32'hAB000000) begin errors++; $display("FAIL ror: got %h want ab000000", result); end
    run_op(4'h0, 4'd0, 0, 3'b010, 4, 32'h1, 32'h1, 0, lat);
    checks++; if (result !== 32'h11) begin errors++; $display("FAIL lsl_add: got %h want 11", result); end
    run_op(4'h3, 4'd0, 0, 3'b001, 0, 32'h0, 32'h1234, 0, lat);
    checks++; if (result !== 32'h1234) begin errors++; $display("FAIL lsr_zero: got %h want 1234", result); end
    checks++; if (flags !== 4'b0101) begin errors++; $display("FAIL shift_flags_hold: got %b want 0101", flags); end
  endtask
  task automatic test_misc;
    run_op(4'h6, 4'd0, 0, 3'b000, 0, 32'h12345678, 32'h0, 16'hBEEF, lat);
    checks++; if (result !== 32'h0000BEEF) begin errors++; $display("FAIL movi: got %h want 0000beef", result); end
    run_op(4'hF, 4'd0, 1, 3'b000, 0, 32'h5, 32'h5, 0, lat);
    checks++; if ({result, flags} !== {32'h0, 4'b0101}) begin errors++; $display("FAIL unknown_op: got %h/%b want 0/0101", result, flags); end
    run_op(4'h5, 4'd0, 1, 3'b000, 0, 32'hF0F0F0F0, 32'hFFFFFFFF, 0, lat);
    checks++; if ({result, flags} !== {32'h0F0F0F0F, 4'b0000}) begin errors++; $display("FAIL xor: got %h/%b want 0f0f0f0f/0000", result, flags); end
  endtask
  task automatic test_back_to_back;
    run_op(4'h0, 4'd0, 0, 3'b000, 0, 32'd1, 32'd2, 0, lat);
    checks++; if ({out_valid, in_ready, result} !== {2'b10, 32'd3}) begin errors++; $display("FAIL b2b_first: got %b%b/%h want 10/3", out_valid, in_ready, result); end
    @(posedge clk); #1;
    checks++; if ({out_valid, in_ready, result} !== {2'b01, 32'd3}) begin errors++; $display("FAIL b2b_hold: got %b%b/%h want 01/3", out_valid, in_ready, result); end
    run_op(4'h0, 4'd0, 0, 3'b000, 0, 32'd10, 32'd20, 0, lat);
    checks++; if (result !== 32'd30) begin errors++; $display("FAIL b2b_second: got %h want 1e", result); end
  endtask
  task automatic test_div;
`ifdef ALU_SEQ_DIV_EN
    run_op(4'h8, 4'd0, 1, 3'b000, 0, 32'd100, 32'd7, 0, lat);
    checks++; if (lat !== 33) begin errors++; $display("FAIL div_latency: got %0d want 33", lat); end
    checks++; if ({result, div_zero, flags} !== {32'd14, 1'b0, 4'b0000}) begin errors++; $display("FAIL div_result: got %h/%b/%b want e/0/0000", result, div_zero, flags); end
    run_op(4'h8, 4'd0, 1, 3'b000, 0, 32'd55, 32'd0, 0, lat);
    checks++; if ({lat == 1, result, div_zero, flags} !== {1'b1, 32'hFFFFFFFF, 1'b1, 4'b1000}) begin errors++; $display("FAIL div_zero: got lat %0d %h/%b/%b want 1 ffffffff/1/1000", lat, result, div_zero, flags); end
`else
    run_op(4'h8, 4'd0, 1, 3'b000, 0, 32'd100, 32'd7, 0, lat);
    checks++; if ({lat == 1, result, div_zero, flags} !== {1'b1, 32'h0, 1'b0, 4'b0000}) begin errors++; $display("FAIL div_disabled: got lat %0d %h/%b/%b want 1 0/0/0000", lat, result, div_zero, flags); end
`endif
  endtask
  task automatic test_reset_mid_mul;
    int seen = 0;
    @(negedge clk);
    opcode = 4'h2; cond = 0; s = 1; sr_cont = 0; sr_bit = 0; in1 = 32'd7; in2 = 32'd9; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1;
    @(posedge clk); #1; rst = 0;
    checks++; if ({in_ready, out_valid, flags, result} !== {2'b10, 4'b0000, 32'h0}) begin errors++; $display("FAIL rst_mid_mul: got %b%b/%b/%h want 10/0000/0", in_ready, out_valid, flags, result); end
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_mul_pulse: got %0d out_valid cycles want 0", seen); end
  endtask
  initial begin
    test_reset;
    test_add;
    test_cmp;
    test_cond;
    test_mul;
    test_shift;
    test_misc;
    test_back_to_back;
    test_div;
    test_reset_mid_mul;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
